fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_rd_adapter.sv | 113 +++++++++++
 tb/tb_fifo_rd_adapter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO family of blocks.
`default_nettype none

package fifo_pkg;

  // Occupancy of the 2-entry read-adapter skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Number of words the adapter's local buffer can hold.
  localparam int unsigned ADAPTER_DEPTH = 2;

  function automatic logic [1:0] occ_count(input occ_e s);
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_adapter.sv
// Converts a 1-cycle-latency FIFO read port into a valid/ready stream
// using a 2-entry local buffer and credit-based read issue.
`default_nettype none

module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       occupancy
);

  occ_e             occ_q, occ_d;
  logic             in_flight_q, in_flight_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  logic             w_pop;
  logic [2:0]       w_used;
  logic [2:0]       w_limit;

  assign w_pop = valid_q && m_ready;

  // credit > 0  <=>  occupancy + in_flight < 2 + pop
  assign w_used  = {1'b0, occ_count(occ_q)} + {2'b00, in_flight_q};
  assign w_limit = 3'd2 + {2'b00, w_pop};

  assign fifo_rd_en = rst_n && !fifo_empty && (w_used < w_limit);

  assign m_data    = head_q;
  assign m_valid   = valid_q;
  assign occupancy = occ_count(occ_q);

  always_comb begin
    occ_d       = occ_q;
    head_d      = head_q;
    tail_d      = tail_q;
    in_flight_d = fifo_rd_en;

    case ({in_flight_q, w_pop})
      2'b11: begin
        // The pop frees the head first, so the arriving word lands behind what remains.
        if (occ_q == TWO) begin
          head_d = tail_q;
          tail_d = fifo_dout;
        end else begin
          head_d = fifo_dout;
        end
      end
      2'b01: begin
        if (occ_q == TWO) begin
          head_d = tail_q;
          occ_d  = ONE;
        end else begin
          occ_d  = EMPTY;
        end
      end
      2'b10: begin
        case (occ_q)
          EMPTY: begin
            head_d = fifo_dout;
            occ_d  = ONE;
          end
          ONE: begin
            tail_d = fifo_dout;
            occ_d  = TWO;
          end
          default: begin
            occ_d  = occ_q;
          end
        endcase
      end
      default: begin
        occ_d = occ_q;
      end
    endcase

    valid_d = (occ_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= EMPTY;
      in_flight_q <= 1'b0;
      valid_q     <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      occ_q       <= occ_d;
      in_flight_q <= in_flight_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_flight_q && !w_pop && (occ_q == TWO)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_adapter.sv
// Self-checking bench for fifo_rd_adapter with a behavioural FIFO and stream model.
`default_nettype none

module tb_fifo_rd_adapter;

  localparam int WIDTH = 8;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic [WIDTH-1:0] fifo_dout  = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready    = 1'b0;
  logic [1:0]       occupancy;

  always #5 clk = ~clk;

  fifo_rd_adapter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .occupancy  (occupancy)
  );

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Upstream FIFO: registered empty flag, data valid one cycle after an accepted read.
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty && fifo_q.size() > 0) begin
      fifo_dout <= fifo_q[0];
      sb_q.push_back(fifo_q[0]);
      void'(fifo_q.pop_front());
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Stream model: words held = words arrived - words transferred.
  int               m_occ  = 0;
  int               m_infl = 0;
  int               credit;
  logic             exp_valid, exp_rd, exp_pop;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] hold_data;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("rst_occupancy", 32'(occupancy), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
      m_occ  = 0;
      m_infl = 0;
      hold   = 1'b0;
      sb_q.delete();
    end else begin
      exp_valid = (m_occ != 0);
      exp_pop   = exp_valid && m_ready;
      credit    = 2 - m_occ - m_infl + (exp_pop ? 1 : 0);
      exp_rd    = !fifo_empty && (credit > 0);
      chk("occupancy", 32'(occupancy), 32'(m_occ));
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
      if (hold) chk("hold_data", 32'(m_data), 32'(hold_data));
      if (exp_pop) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 1);
        end else begin
          chk("m_data_order", 32'(m_data), 32'(sb_q.pop_front()));
          n_xfer++;
        end
      end
      hold      = exp_valid && !m_ready;
      hold_data = m_data;
      m_occ     = m_occ + m_infl - (exp_pop ? 1 : 0);
      m_infl    = exp_rd ? 1 : 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int w;
    w = 0;
    while (!m_valid && w < 10) begin
      tick();
      #3;
      w++;
    end
    chk(name, 32'(m_valid), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;

    repeat (3) tick();

    // First word latency.
    fifo_q.push_back(8'hA5);
    m_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    #3;
    chk("fw_c0_rd_en", 32'(fifo_rd_en), 1);
    chk("fw_c0_valid", 32'(m_valid), 0);
    tick(); #3;
    chk("fw_c1_valid", 32'(m_valid), 0);
    chk("fw_c1_rd_en", 32'(fifo_rd_en), 0);
    tick(); #3;
    chk("fw_c2_valid", 32'(m_valid), 1);
    chk("fw_c2_data", 32'(m_data), 32'h A5);
    chk("fw_c2_occ", 32'(occupancy), 1);
    tick(); #3;
    chk("fw_c3_valid", 32'(m_valid), 0);
    chk("fw_c3_occ", 32'(occupancy), 0);

    // Streaming with no bubbles.
    tick();
    for (int i = 0; i < 16; i++) fifo_q.push_back(WIDTH'(i));
    #3;
    wait_valid("stream_start");
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", 32'(m_valid), 1);
      chk("stream_data", 32'(m_data), 32'(i));
      tick(); #3;
    end
    chk("stream_end_valid", 32'(m_valid), 0);

    // Backpressure.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(WIDTH'(i));
    #3;
    repeat (10) begin tick(); #3; end
    chk("bp_occ", 32'(occupancy), 2);
    chk("bp_rd_en", 32'(fifo_rd_en), 0);
    chk("bp_data", 32'(m_data), 0);
    chk("bp_valid", 32'(m_valid), 1);
    tick();
    m_ready = 1'b1;
    #3;
    for (int i = 0; i < 8; i++) begin
      chk("bp_rel_valid", 32'(m_valid), 1);
      chk("bp_rel_data", 32'(m_data), 32'(i));
      tick(); #3;
    end
    chk("bp_end_valid", 32'(m_valid), 0);

    // Reset mid-stream with a full buffer and a read being issued.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(WIDTH'(8'h40 + i));
    #3;
    repeat (6) begin tick(); #3; end
    chk("mr_pre_occ", 32'(occupancy), 2);
    tick();
    m_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    fifo_q.delete();
    #2;
    chk("mr_valid", 32'(m_valid), 0);
    chk("mr_occ", 32'(occupancy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #3;
    chk("mr_rel_rd_en", 32'(fifo_rd_en), 0);
    chk("mr_rel_valid", 32'(m_valid), 0);
    fifo_q.push_back(8'h3C);
    wait_valid("mr_refill_valid");
    chk("mr_refill_data", 32'(m_data), 32'h3C);

    // Random backpressure over a long random stream.
    tick();
    base = n_xfer;
    for (int i = 0; i < 1000; i++) fifo_q.push_back(WIDTH'($urandom));
    cyc = 0;
    while ((n_xfer - base) < 1000 && cyc < 6000) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    chk("random_count", 32'(n_xfer - base), 1000);
    m_ready = 1'b1;
    repeat (4) tick();
    #3;
    chk("random_drained_valid", 32'(m_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
